// File: rtl/cc_result_framer_pkg.sv
// Shared acoustics definitions: frame constants, framer states and the
// UART TX handshake levels also used by the command reader.
package cc_result_framer_pkg;

    localparam logic [7:0] FRAME_SYNC = 8'hA5;

    // Byte index width; covers the longest frame (4 pairs -> 11 bytes).
    localparam int IDX_W = 4;

    localparam logic TX_RDY_IDLE = 1'b1;
    localparam logic TX_RDY_BUSY = 1'b0;
    localparam logic TX_STROBE   = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_LOW,
        ST_WAIT_HIGH,
        ST_DONE
    } frame_state_e;

    function automatic int frame_len(input int num_pairs);
        return 3 + 2 * num_pairs;
    endfunction

endpackage

// File: rtl/cc_result_framer_frame_byte_mux.sv
// Picks the frame byte at a given index: sync, sequence number,
// sign-extended lag bytes (high first) and the trailing checksum.
module frame_byte_mux
    import cc_result_framer_pkg::*;
#(
    parameter int NUM_PAIRS = 3,
    parameter int LAG_W     = 10
) (
    input  logic [IDX_W-1:0]           idx_i,
    input  logic [7:0]                 seq_i,
    input  logic [NUM_PAIRS*LAG_W-1:0] lags_i,
    input  logic [7:0]                 chk_i,
    output logic [7:0]                 byte_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(frame_len(NUM_PAIRS) - 1);

    logic [LAG_W-1:0] lag;
    logic [15:0]      lag16;

    // Pair p owns indices 2+2p and 3+2p, i.e. idx>>1 == p+1.
    always_comb begin
        lag = '0;
        for (int p = 0; p < NUM_PAIRS; p++) begin
            if (idx_i[IDX_W-1:1] == (IDX_W-1)'(p + 1)) begin
                lag = lags_i[p*LAG_W +: LAG_W];
            end
        end
    end

    assign lag16 = 16'($signed(lag));

    always_comb begin
        byte_o = 8'h00;
        unique case (1'b1)
            (idx_i == '0):             byte_o = FRAME_SYNC;
            (idx_i == IDX_W'(1)):      byte_o = seq_i;
            (idx_i == LAST_IDX):       byte_o = chk_i;
            default:                   byte_o = idx_i[0] ? lag16[7:0] : lag16[15:8];
        endcase
    end

endmodule

// File: rtl/cc_result_framer.sv
// Snapshots cross-correlation lag results on CC_Done and streams them to
// the UART as a sync/seq/lags/checksum frame over the TX handshake.
module cc_result_framer
    import cc_result_framer_pkg::*;
#(
    parameter int NUM_PAIRS   = 3,
    parameter int LAG_W       = 10,
    parameter int ACK_TIMEOUT = 4095
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic             Lag_Valid,
    input  logic [1:0]       Lag_Pair_sel,
    input  logic [LAG_W-1:0] Lag_Value,
    input  logic             CC_Done,
    input  logic             Tx_Ready,
    output logic [7:0]       Word_To_Send,
    output logic             TX_en,
    output logic             TX_Write_en,
    output logic             Busy,
    output logic             Frame_Sent,
    output logic             Overrun,
    output logic             Timeout_Err
);

    localparam int SLOT_W = NUM_PAIRS * LAG_W;
    localparam int TW     = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0]    TO_MAX   = TW'(ACK_TIMEOUT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(frame_len(NUM_PAIRS) - 1);

    frame_state_e      state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [7:0]        seq_q, seq_d;
    logic [7:0]        chk_q, chk_d;
    logic [TW-1:0]     cnt_q, cnt_d;
    logic [SLOT_W-1:0] slots_q, slots_d;
    logic [SLOT_W-1:0] shadow_q, shadow_d;
    logic [7:0]        word_q, word_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              sent_q, sent_d;
    logic              ovr_q, ovr_d;
    logic              tmo_q, tmo_d;
    logic [7:0]        cur_byte;

    frame_byte_mux #(
        .NUM_PAIRS (NUM_PAIRS),
        .LAG_W     (LAG_W)
    ) u_byte_mux (
        .idx_i  (idx_q),
        .seq_i  (seq_q),
        .lags_i (shadow_q),
        .chk_i  (chk_q),
        .byte_o (cur_byte)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        seq_d    = seq_q;
        chk_d    = chk_q;
        cnt_d    = cnt_q;
        slots_d  = slots_q;
        shadow_d = shadow_q;
        word_d   = word_q;
        tx_d     = 1'b0;
        sent_d   = 1'b0;
        ovr_d    = ovr_q;
        tmo_d    = tmo_q;

        for (int p = 0; p < NUM_PAIRS; p++) begin
            if (Lag_Valid && Lag_Pair_sel == 2'(p)) begin
                slots_d[p*LAG_W +: LAG_W] = Lag_Value;
            end
        end

        if (CC_Done && state_q != ST_IDLE) begin
            ovr_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                // slots_q is the pre-write value if Lag_Valid coincides
                if (CC_Done) begin
                    shadow_d = slots_q;
                    idx_d    = '0;
                    chk_d    = 8'h00;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (Tx_Ready == TX_RDY_IDLE) begin
                    tx_d    = TX_STROBE;
                    word_d  = cur_byte;
                    cnt_d   = '0;
                    state_d = ST_WAIT_LOW;
                    if (idx_q != '0) begin
                        chk_d = chk_q ^ cur_byte;
                    end
                end
            end
            ST_WAIT_LOW: begin
                if (Tx_Ready == TX_RDY_BUSY) begin
                    state_d = ST_WAIT_HIGH;
                end else if (cnt_q >= TO_MAX) begin
                    tmo_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            ST_WAIT_HIGH: begin
                if (Tx_Ready == TX_RDY_IDLE) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_DONE: begin
                sent_d  = 1'b1;
                seq_d   = seq_q + 8'd1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            seq_q    <= 8'h00;
            chk_q    <= 8'h00;
            cnt_q    <= '0;
            slots_q  <= '0;
            shadow_q <= '0;
            word_q   <= 8'h00;
            tx_q     <= 1'b0;
            busy_q   <= 1'b0;
            sent_q   <= 1'b0;
            ovr_q    <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            seq_q    <= seq_d;
            chk_q    <= chk_d;
            cnt_q    <= cnt_d;
            slots_q  <= slots_d;
            shadow_q <= shadow_d;
            word_q   <= word_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            sent_q   <= sent_d;
            ovr_q    <= ovr_d;
            tmo_q    <= tmo_d;
        end
    end

    assign Word_To_Send = word_q;
    assign TX_en        = tx_q;
    assign TX_Write_en  = tx_q;
    assign Busy         = busy_q;
    assign Frame_Sent   = sent_q;
    assign Overrun      = ovr_q;
    assign Timeout_Err  = tmo_q;

endmodule

// File: tb/tb_cc_result_framer.sv
// Randomized bench for cc_result_framer with a UART responder and a
// frame-level reference model.
module tb_cc_result_framer;

    localparam int NP = 3;
    localparam int LW = 10;
    localparam int TO = 4095;

    logic          clk = 1'b0;
    logic          reset_b;
    logic          Lag_Valid;
    logic [1:0]    Lag_Pair_sel;
    logic [LW-1:0] Lag_Value;
    logic          CC_Done;
    logic          Tx_Ready;
    logic [7:0]    Word_To_Send;
    logic          TX_en;
    logic          TX_Write_en;
    logic          Busy;
    logic          Frame_Sent;
    logic          Overrun;
    logic          Timeout_Err;

    cc_result_framer #(
        .NUM_PAIRS   (NP),
        .LAG_W       (LW),
        .ACK_TIMEOUT (TO)
    ) dut (
        .clk          (clk),
        .reset_b      (reset_b),
        .Lag_Valid    (Lag_Valid),
        .Lag_Pair_sel (Lag_Pair_sel),
        .Lag_Value    (Lag_Value),
        .CC_Done      (CC_Done),
        .Tx_Ready     (Tx_Ready),
        .Word_To_Send (Word_To_Send),
        .TX_en        (TX_en),
        .TX_Write_en  (TX_Write_en),
        .Busy         (Busy),
        .Frame_Sent   (Frame_Sent),
        .Overrun      (Overrun),
        .Timeout_Err  (Timeout_Err)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    int         slot_m[NP];
    int         seq_m = 0;
    logic [7:0] exp_q[$];
    logic [7:0] cap[$];
    bit         rearmed = 1'b1;
    bit         prev_rdy = 1'b1;
    bit         uart_hang = 1'b0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Frame from the rules: sync, seq, 16-bit lags hi/lo, XOR of bytes after sync.
    function automatic void build_frame(input int sh[NP]);
        int         v;
        logic [7:0] c;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'(seq_m));
        c = 8'(seq_m);
        for (int p = 0; p < NP; p++) begin
            v = sh[p] & 32'hFFFF;
            exp_q.push_back(8'(v >> 8));
            exp_q.push_back(8'(v));
            c = c ^ 8'(v >> 8) ^ 8'(v);
        end
        exp_q.push_back(c);
    endfunction

    // UART model: accepts a strobe, drops ready, then raises it again.
    initial begin
        int d;
        Tx_Ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (TX_en) begin
                if (uart_hang) wait (!uart_hang);
                d = $urandom_range(0, 2);
                repeat (d) @(posedge clk);
                #2;
                Tx_Ready = 1'b0;
                d = $urandom_range(1, 3);
                repeat (d) @(posedge clk);
                #2;
                Tx_Ready = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (!prev_rdy && Tx_Ready) rearmed = 1'b1;
        prev_rdy = Tx_Ready;
        if (TX_en || TX_Write_en) begin
            check("strobe_pair", 32'(TX_Write_en), 32'(TX_en));
            check("word_known", 32'($isunknown(Word_To_Send)), 32'd0);
            check("rearm", 32'(rearmed), 32'd1);
            rearmed = 1'b0;
            cap.push_back(Word_To_Send);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_lag(input int sel, input int val);
        Lag_Valid    = 1'b1;
        Lag_Pair_sel = 2'(sel);
        Lag_Value    = LW'(val);
        tick(1);
        Lag_Valid = 1'b0;
        if (sel < NP) slot_m[sel] = val;
    endtask

    task automatic start_frame(input bit wr, input int sel, input int val);
        int sh[NP];
        sh = slot_m;
        build_frame(sh);
        cap.delete();
        CC_Done = 1'b1;
        if (wr) begin
            Lag_Valid    = 1'b1;
            Lag_Pair_sel = 2'(sel);
            Lag_Value    = LW'(val);
        end
        tick(1);
        CC_Done   = 1'b0;
        Lag_Valid = 1'b0;
        if (wr && sel < NP) slot_m[sel] = val;
        check("busy_rise", 32'(Busy), 32'd1);
    endtask

    task automatic wait_sent(input string tag);
        bit got = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (Frame_Sent) begin
                got = 1'b1;
                break;
            end
        end
        check({tag, "_sent"}, 32'(got), 32'd1);
        check({tag, "_busy_fall"}, 32'(Busy), 32'd0);
        check({tag, "_len"}, 32'(cap.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s_b%0d", tag, i),
                  (i < cap.size()) ? 32'(cap[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
        end
        if (got) seq_m = (seq_m + 1) & 255;
        tick(1);
        check({tag, "_sent_pulse"}, 32'(Frame_Sent), 32'd0);
    endtask

    task automatic wait_strobes(input int n);
        bit got = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (cap.size() >= n) begin
                got = 1'b1;
                break;
            end
        end
        check("strobe_wait", 32'(got), 32'd1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_word"}, 32'(Word_To_Send), 32'd0);
        check({tag, "_txen"}, 32'(TX_en), 32'd0);
        check({tag, "_txwr"}, 32'(TX_Write_en), 32'd0);
        check({tag, "_busy"}, 32'(Busy), 32'd0);
        check({tag, "_sent"}, 32'(Frame_Sent), 32'd0);
        check({tag, "_ovr"}, 32'(Overrun), 32'd0);
        check({tag, "_tmo"}, 32'(Timeout_Err), 32'd0);
    endtask

    initial begin
        logic [7:0] lit[9];
        int         n;
        bit         got;

        reset_b      = 1'b0;
        Lag_Valid    = 1'b0;
        Lag_Pair_sel = 2'd0;
        Lag_Value    = '0;
        CC_Done      = 1'b0;
        for (int p = 0; p < NP; p++) slot_m[p] = 0;
        #3;
        check_zero("rst");
        tick(3);
        check_zero("rst_hold");
        reset_b = 1'b1;
        tick(2);

        // Directed frame {5,-3,0}, seq 0
        write_lag(0, 5);
        write_lag(1, -3);
        write_lag(2, 0);
        start_frame(1'b0, 0, 0);
        wait_sent("dir");
        lit = '{8'hA5, 8'h00, 8'h00, 8'h05, 8'hFF, 8'hFD, 8'h00, 8'h00, 8'h07};
        for (int i = 0; i < 9; i++) begin
            check($sformatf("dir_lit%0d", i),
                  (i < cap.size()) ? 32'(cap[i]) : 32'hFFFF_FFFF, 32'(lit[i]));
        end
        start_frame(1'b0, 0, 0);
        wait_sent("dir2");
        check("dir2_seq", (cap.size() > 1) ? 32'(cap[1]) : 32'hFFFF_FFFF, 32'h01);

        // Random lags, including writes to the ignored slot 3
        for (int f = 0; f < 12; f++) begin
            n = $urandom_range(0, 4);
            for (int k = 0; k < n; k++) begin
                write_lag($urandom_range(0, 3), $urandom_range(0, 1023) - 512);
            end
            start_frame($urandom_range(0, 1), $urandom_range(0, 3),
                        $urandom_range(0, 1023) - 512);
            wait_sent($sformatf("rnd%0d", f));
        end

        // Coincident Lag_Valid and CC_Done: frame keeps the old slot value
        write_lag(1, 2);
        start_frame(1'b1, 1, -1);
        wait_sent("coin");
        check("coin_hi", (cap.size() > 5) ? 32'(cap[4]) : 32'hFFFF_FFFF, 32'h00);
        check("coin_lo", (cap.size() > 5) ? 32'(cap[5]) : 32'hFFFF_FFFF, 32'h02);
        start_frame(1'b0, 0, 0);
        wait_sent("coin2");
        check("coin2_hi", (cap.size() > 5) ? 32'(cap[4]) : 32'hFFFF_FFFF, 32'hFF);
        check("coin2_lo", (cap.size() > 5) ? 32'(cap[5]) : 32'hFFFF_FFFF, 32'hFF);

        // CC_Done mid-frame: overrun, frame unchanged, no second frame
        check("ovr_before", 32'(Overrun), 32'd0);
        start_frame(1'b0, 0, 0);
        wait_strobes(5);
        #1;
        CC_Done = 1'b1;
        tick(1);
        CC_Done = 1'b0;
        check("ovr_set", 32'(Overrun), 32'd1);
        wait_sent("ovr");
        tick(30);
        check("ovr_count", 32'(cap.size()), 32'd9);
        check("ovr_idle", 32'(Busy), 32'd0);

        // Ack timeout: UART never drops ready
        uart_hang = 1'b1;
        start_frame(1'b0, 0, 0);
        got = 1'b0;
        n   = 0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            n++;
            if (Timeout_Err) begin
                got = 1'b1;
                break;
            end
        end
        check("tmo_set", 32'(got), 32'd1);
        check("tmo_window", 32'(n >= 4090 && n <= 4105), 32'd1);
        check("tmo_busy", 32'(Busy), 32'd0);
        tick(30);
        check("tmo_strobes", 32'(cap.size()), 32'd1);
        check("tmo_sticky", 32'(Timeout_Err), 32'd1);
        check("ovr_sticky", 32'(Overrun), 32'd1);
        uart_hang = 1'b0;
        tick(30);

        // 256 back-to-back frames; seq continues from the unchanged value
        for (int f = 0; f < 256; f++) begin
            if (f % 37 == 0) write_lag($urandom_range(0, 2), $urandom_range(0, 1023) - 512);
            start_frame(1'b0, 0, 0);
            wait_sent($sformatf("b2b%0d", f));
        end
        start_frame(1'b0, 0, 0);
        wait_sent("wrap");

        // Reset while waiting for ready-high after byte 3
        start_frame(1'b0, 0, 0);
        wait_strobes(4);
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (Tx_Ready == 1'b0) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("mid_low_seen", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        reset_b = 1'b0;
        #1;
        check_zero("mid_rst");
        tick(3);
        reset_b = 1'b1;
        for (int p = 0; p < NP; p++) slot_m[p] = 0;
        seq_m = 0;
        tick(50);
        check("mid_no_strobe", 32'(cap.size()), 32'd4);
        check("mid_idle", 32'(Busy), 32'd0);
        start_frame(1'b0, 0, 0);
        wait_sent("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
